// File: rtl/div_ctrl_pkg.sv
// Shared encodings and sideband layout for the RV32M divide
// sequencer that wraps the unsigned pipelined divider.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  localparam int XLEN = 32;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef struct packed {
    logic        valid;
    op_e         op;
    logic        neg_q;
    logic        neg_r;
    logic        dz;
    logic        ovf;
    logic [31:0] a;
  } sb_t;

  function automatic logic is_signed_op(input op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem_op(input op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  // INT_MIN negates to itself, which is exactly its 2^31 magnitude.
  function automatic logic [31:0] magnitude(
    input logic [31:0] v,
    input logic        sgn
  );
    return (sgn && v[31]) ? 32'(-v) : v;
  endfunction

endpackage

// File: rtl/div_result_fifo.sv
// Result buffer between the non-stallable divider return path
// and the writeback handshake; flops only, flushable.
module div_result_fifo
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] rdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q;
  logic [PW-1:0]    wr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_pop;

  function automatic logic [PW-1:0] bump(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign valid  = (cnt_q != '0);
  assign rdata  = mem_q[rd_q];
  assign do_pop = pop & valid;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= wdata;
        wr_q        <= bump(wr_q);
      end
      if (do_pop) begin
        rd_q <= bump(rd_q);
      end
      if (push && !do_pop) begin
        cnt_q <= cnt_q + CW'(1);
      end else if (!push && do_pop) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  ap_no_overflow: assert property (
    @(posedge clk_i) disable iff (rst_i)
    push |-> (cnt_q != CW'(DEPTH))
  );

endmodule

// File: rtl/div_unit_ctrl.sv
// RV32M divide sequencer: credit-gated issue, sign conditioning,
// sideband pipe matched to divider latency, result fixup.
module div_unit_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DIV_LATENCY = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int TAG_W       = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic [31:0]      req_a_i,
  input  logic [31:0]      req_b_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             div_en_o,
  output logic [31:0]      div_dividend_o,
  output logic [31:0]      div_divisor_o,
  input  logic [31:0]      div_quo_i,
  input  logic [31:0]      div_rem_i,
  input  logic             div_ack_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_data_o,
  output logic [TAG_W-1:0] rsp_tag_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int FW = XLEN + TAG_W;

  logic [CW-1:0]          credits_q;
  logic                   accept;
  logic                   pop;
  logic                   push;
  logic                   sgn;
  op_e                    op_in;
  sb_t                    sb_in;
  sb_t                    sb_q  [DIV_LATENCY];
  logic [TAG_W-1:0]       tag_q [DIV_LATENCY];
  logic [DIV_LATENCY-1:0] busy_q;
  sb_t                    tail;
  logic [31:0]            fix_data;
  logic [FW-1:0]          fifo_rdata;

  assign op_in  = op_e'(req_op_i);
  assign sgn    = is_signed_op(op_in);

  assign req_ready_o = ~rst_i & ~flush_i
                     & (credits_q != '0);
  assign accept      = req_valid_i & req_ready_o;
  assign pop         = rsp_valid_o & rsp_ready_i;

  assign div_en_o       = accept;
  assign div_dividend_o = magnitude(req_a_i, sgn);
  assign div_divisor_o  = magnitude(req_b_i, sgn);

  always_comb begin
    sb_in       = '0;
    sb_in.valid = accept;
    sb_in.op    = op_in;
    sb_in.neg_q = sgn & (req_a_i[31] ^ req_b_i[31]);
    sb_in.neg_r = sgn & req_a_i[31];
    sb_in.dz    = (req_b_i == '0);
    sb_in.ovf   = sgn & (req_a_i == INT_MIN)
                & (req_b_i == ALL_ONES);
    sb_in.a     = req_a_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      credits_q <= CW'(FIFO_DEPTH);
    end else if (flush_i) begin
      credits_q <= CW'(FIFO_DEPTH);
    end else if (accept && !pop) begin
      credits_q <= credits_q - CW'(1);
    end else if (pop && !accept) begin
      credits_q <= credits_q + CW'(1);
    end
  end

  // busy_q tracks real divider occupancy and survives flush,
  // so acks for flushed ops are expected rather than errors.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= '0;
      for (int i = 0; i < DIV_LATENCY; i++) begin
        sb_q[i]  <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      busy_q   <= (busy_q << 1) | DIV_LATENCY'(accept);
      sb_q[0]  <= sb_in;
      tag_q[0] <= req_tag_i;
      for (int i = 1; i < DIV_LATENCY; i++) begin
        sb_q[i]       <= sb_q[i-1];
        sb_q[i].valid <= sb_q[i-1].valid & ~flush_i;
        tag_q[i]      <= tag_q[i-1];
      end
    end
  end

  assign tail = sb_q[DIV_LATENCY-1];
  assign push = tail.valid & ~flush_i;

  always_comb begin
    fix_data = '0;
    unique case (1'b1)
      tail.dz: begin
        fix_data = is_rem_op(tail.op) ? tail.a
                                      : ALL_ONES;
      end
      tail.ovf: begin
        fix_data = is_rem_op(tail.op) ? '0 : INT_MIN;
      end
      default: begin
        if (is_rem_op(tail.op)) begin
          fix_data = tail.neg_r ? 32'(-div_rem_i)
                                : div_rem_i;
        end else begin
          fix_data = tail.neg_q ? 32'(-div_quo_i)
                                : div_quo_i;
        end
      end
    endcase
  end

  div_result_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .flush (flush_i),
    .push  (push),
    .wdata ({tag_q[DIV_LATENCY-1], fix_data}),
    .pop   (pop),
    .valid (rsp_valid_o),
    .rdata (fifo_rdata)
  );

  assign rsp_data_o = fifo_rdata[XLEN-1:0];
  assign rsp_tag_o  = fifo_rdata[XLEN +: TAG_W];

  ap_ack_aligned: assert property (
    @(posedge clk_i) disable iff (rst_i)
    div_ack_i == busy_q[DIV_LATENCY-1]
  );

  ap_tail_has_ack: assert property (
    @(posedge clk_i) disable iff (rst_i)
    tail.valid |-> div_ack_i
  );

endmodule

// File: tb/tb_div_unit_ctrl.sv
// Scoreboard bench for div_unit_ctrl with a behavioural divider
// and a signed/unsigned RISC-V reference model.
module tb_div_unit_ctrl;

  localparam int LAT = 4;
  localparam int DEP = 4;
  localparam int TW  = 5;

  logic          clk = 0;
  logic          rst = 1;
  logic          flush = 0;
  logic          req_valid = 0;
  logic          req_ready;
  logic [1:0]    req_op = 0;
  logic [31:0]   req_a = 0;
  logic [31:0]   req_b = 0;
  logic [TW-1:0] req_tag = 0;
  logic          div_en;
  logic [31:0]   div_dividend;
  logic [31:0]   div_divisor;
  logic [31:0]   div_quo;
  logic [31:0]   div_rem;
  logic          div_ack;
  logic          rsp_valid;
  logic          rsp_ready = 0;
  logic [31:0]   rsp_data;
  logic [TW-1:0] rsp_tag;

  always #5 clk = ~clk;

  div_unit_ctrl #(
    .DIV_LATENCY (LAT),
    .FIFO_DEPTH  (DEP),
    .TAG_W       (TW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_op_i       (req_op),
    .req_a_i        (req_a),
    .req_b_i        (req_b),
    .req_tag_i      (req_tag),
    .div_en_o       (div_en),
    .div_dividend_o (div_dividend),
    .div_divisor_o  (div_divisor),
    .div_quo_i      (div_quo),
    .div_rem_i      (div_rem),
    .div_ack_i      (div_ack),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_data_o     (rsp_data),
    .rsp_tag_o      (rsp_tag)
  );

  // Unsigned divider environment: LAT register stages.
  logic [LAT-1:0] d_en;
  logic [31:0]    d_n [LAT];
  logic [31:0]    d_d [LAT];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      d_en <= '0;
      for (int i = 0; i < LAT; i++) begin
        d_n[i] <= '0;
        d_d[i] <= '0;
      end
    end else begin
      d_en   <= {d_en[LAT-2:0], div_en};
      d_n[0] <= div_dividend;
      d_d[0] <= div_divisor;
      for (int i = 1; i < LAT; i++) begin
        d_n[i] <= d_n[i-1];
        d_d[i] <= d_d[i-1];
      end
    end
  end

  assign div_ack = d_en[LAT-1];
  assign div_quo = (d_d[LAT-1] == 0) ? 32'hFFFF_FFFF
                 : d_n[LAT-1] / d_d[LAT-1];
  assign div_rem = (d_d[LAT-1] == 0) ? d_n[LAT-1]
                 : d_n[LAT-1] % d_d[LAT-1];

  // RISC-V M-extension semantics in plain integer arithmetic.
  function automatic logic [31:0] ref_res(
    input logic [1:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    int sa;
    int sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b00: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      2'b01: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      2'b10: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  typedef struct {
    logic [TW-1:0] tag;
    logic [31:0]   data;
    int            acc;
    bit            exact;
    bit            seen;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_rsp = 0;
  int   cyc = 0;
  bit   exact_mode = 0;

  function automatic void chk(
    input bit          ok,
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, act, exp);
    end
  endfunction

  // Monitor: response check first, then flush, then accept.
  always @(negedge clk) begin
    exp_t h;
    int   lat;
    cyc++;
    if (rst) begin
      chk(!rsp_valid && !req_ready && !div_en &&
          rsp_data == 0 && rsp_tag == 0,
          "reset_outputs",
          64'({rsp_valid, req_ready, div_en,
               rsp_tag, rsp_data}), 64'(0));
      q.delete();
    end else begin
      if (rsp_valid) begin
        chk(q.size() > 0, "rsp_expected",
            64'(q.size()), 64'(1));
        if (q.size() > 0) begin
          h = q[0];
          chk(rsp_tag == h.tag && rsp_data == h.data,
              "rsp_tag_data",
              64'({rsp_tag, rsp_data}),
              64'({h.tag, h.data}));
          if (!h.seen) begin
            lat = cyc - h.acc;
            if (h.exact)
              chk(lat == LAT + 1, "latency_exact",
                  64'(lat), 64'(LAT + 1));
            else
              chk(lat >= LAT + 1, "latency_min",
                  64'(lat), 64'(LAT + 1));
            q[0].seen = 1;
          end
          if (rsp_ready) begin
            void'(q.pop_front());
            n_rsp++;
          end
        end
      end
      if (flush) q.delete();
      if (req_valid && req_ready) begin
        h.tag   = req_tag;
        h.data  = ref_res(req_op, req_a, req_b);
        h.acc   = cyc;
        h.exact = exact_mode;
        h.seen  = 0;
        q.push_back(h);
      end
    end
  end

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(9));
      4: return 32'h0 - 32'($urandom_range(9));
      default: return $urandom();
    endcase
  endfunction

  task automatic set_req(
    input logic [1:0]    op,
    input logic [31:0]   a,
    input logic [31:0]   b,
    input logic [TW-1:0] tag
  );
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    req_valid = 1;
  endtask

  task automatic set_rnd(input logic [TW-1:0] tag);
    set_req(2'($urandom_range(3)), rnd_operand(),
            rnd_operand(), tag);
  endtask

  task automatic send(
    input logic [1:0]    op,
    input logic [31:0]   a,
    input logic [31:0]   b,
    input logic [TW-1:0] tag
  );
    bit ok;
    ok = 0;
    set_req(op, a, b, tag);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
    end
    chk(ok, "send_accept", 64'(ok), 64'(1));
    @(posedge clk);
    #1;
    req_valid = 0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    rsp_ready = 1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0 && !rsp_valid) done = 1;
    end
    chk(done, "drain", 64'(q.size()), 64'(0));
    repeat (LAT + 4) @(posedge clk);
    #1;
  endtask

  task automatic count_accepts(
    input  int cycles,
    output int n
  );
    n = 0;
    rsp_ready = 0;
    set_rnd(TW'(20));
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (req_ready) n++;
      @(posedge clk);
      #1;
      set_rnd(TW'(20 + n));
    end
    req_valid = 0;
  endtask

  logic [1:0]  d_op [8];
  logic [31:0] d_a  [8];
  logic [31:0] d_b  [8];

  initial begin
    int k;
    int n;
    int r0;
    int sent;
    bit pend;

    d_op[0] = 2'b00; d_a[0] = -32'sd20;      d_b[0] = 32'd3;
    d_op[1] = 2'b10; d_a[1] = -32'sd20;      d_b[1] = 32'd3;
    d_op[2] = 2'b11; d_a[2] = 32'd20;        d_b[2] = 32'd3;
    d_op[3] = 2'b01; d_a[3] = 32'hFFFF_FFFF; d_b[3] = 32'd2;
    d_op[4] = 2'b00; d_a[4] = 32'd123;       d_b[4] = 32'd0;
    d_op[5] = 2'b10; d_a[5] = 32'd123;       d_b[5] = 32'd0;
    d_op[6] = 2'b00; d_a[6] = 32'h8000_0000; d_b[6] = 32'hFFFF_FFFF;
    d_op[7] = 2'b10; d_a[7] = 32'h8000_0000; d_b[7] = 32'hFFFF_FFFF;

    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk(req_ready == 1, "ready_after_reset",
        64'(req_ready), 64'(1));

    // Directed ops, each on an idle pipe.
    exact_mode = 1;
    rsp_ready  = 1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      send(d_op[i], d_a[i], d_b[i],
           (i == 0) ? TW'(7) : TW'(i + 10));
      drain();
    end

    // Backpressure: tags 0..7 with consumer stalled.
    exact_mode = 0;
    rsp_ready  = 0;
    r0 = n_rsp;
    k  = 0;
    @(posedge clk);
    #1;
    set_rnd(TW'(k));
    for (int c = 0; c < 80 && k < 8; c++) begin
      @(negedge clk);
      if (req_ready) k++;
      if (c == 11) begin
        chk(k == DEP, "bp_accepted",
            64'(k), 64'(DEP));
        chk(req_ready == 0, "bp_ready_low",
            64'(req_ready), 64'(0));
      end
      @(posedge clk);
      #1;
      if (c == 11) rsp_ready = 1;
      if (k < 8) set_rnd(TW'(k));
      else req_valid = 0;
    end
    req_valid = 0;
    chk(k == 8, "bp_all_sent", 64'(k), 64'(8));
    drain();
    chk(n_rsp - r0 == 8, "bp_rsp_count",
        64'(n_rsp - r0), 64'(8));

    // Flush two cycles after three issues.
    send(2'b00, 32'd100, 32'd7, TW'(1));
    send(2'b01, 32'd200, 32'd9, TW'(2));
    send(2'b10, 32'd300, 32'd11, TW'(3));
    @(posedge clk);
    #1;
    flush = 1;
    set_req(2'b00, -32'sd50, 32'd4, TW'(9));
    @(negedge clk);
    chk(req_ready == 0, "flush_blocks_req",
        64'(req_ready), 64'(0));
    @(posedge clk);
    #1;
    flush = 0;
    exact_mode = 1;
    r0 = n_rsp;
    send(2'b00, -32'sd50, 32'd4, TW'(9));
    drain();
    exact_mode = 0;
    chk(n_rsp - r0 == 1, "flush_single_rsp",
        64'(n_rsp - r0), 64'(1));
    count_accepts(10, n);
    chk(n == DEP, "credits_restored",
        64'(n), 64'(DEP));
    drain();

    // Randomized traffic with random backpressure.
    sent = 0;
    pend = 0;
    for (int c = 0; c < 4000 && sent < 300; c++) begin
      @(posedge clk);
      #1;
      rsp_ready = ($urandom_range(3) != 0);
      if (!pend) begin
        req_valid = 0;
        if ($urandom_range(3) != 0) begin
          set_rnd(TW'($urandom_range(31)));
          pend = 1;
        end
      end
      @(negedge clk);
      if (req_valid && req_ready) begin
        pend = 0;
        sent++;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 0;
    chk(sent == 300, "random_sent", 64'(sent), 64'(300));
    drain();

    // Reset pulse with ops in flight.
    send(2'b00, 32'd77, 32'd5, TW'(4));
    send(2'b11, 32'd78, 32'd5, TW'(5));
    send(2'b10, -32'sd79, 32'd5, TW'(6));
    rsp_ready = 0;
    @(posedge clk);
    #1;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk(req_ready == 1, "ready_after_midreset",
        64'(req_ready), 64'(1));
    drain();
    exact_mode = 1;
    send(2'b10, -32'sd20, 32'd3, TW'(12));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
